// File: rtl/neuron_accum_ctrl.sv
// Neuron dot-product sequencer: loads a bias, streams N_INPUTS signed samples
// through the shared registered adder, saturates to 16b and offers the result.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; bias captured into acc on accept
// ISSUE   | in_ready high; a valid sample is handed to the adder this edge
// CAPTURE | adder total available; saturate into acc, advance sample count
// DONE    | result offered on out_valid until out_ready
module neuron_accum_ctrl #(
  parameter  int N_INPUTS = 8,
  localparam int CNT_W    = $clog2(N_INPUTS + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_bias,
  input  logic        i_in_valid,
  input  logic [7:0]  i_in_data,
  output logic        o_in_ready,
  output logic [15:0] o_add_in1,
  output logic [7:0]  o_add_in2,
  input  logic [16:0] i_add_total,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [15:0] o_out_data,
  output logic        o_out_ovf,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;

  logic              w_ovf;
  logic [15:0]       w_sat;
  logic              w_last;
  logic              w_in_ready;

  // A 17b total whose top two bits disagree no longer fits in 16b signed.
  assign w_ovf  = i_add_total[16] ^ i_add_total[15];
  assign w_sat  = !w_ovf          ? i_add_total[15:0] :
                  i_add_total[16] ? 16'h8000 : 16'h7FFF;
  assign w_last = (r_cnt == LAST_CNT);
  assign w_in_ready = (r_state == S_ISSUE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= 16'd0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc <= i_bias;
            r_cnt <= '0;
            r_ovf <= 1'b0;
          end
        end
        S_CAPTURE: begin
          r_acc <= w_sat;
          r_ovf <= r_ovf | w_ovf;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start)     w_next = S_ISSUE;
      S_ISSUE:   if (i_in_valid)  w_next = S_CAPTURE;
      S_CAPTURE: w_next = w_last ? S_DONE : S_ISSUE;
      S_DONE:    if (i_out_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready  = w_in_ready;
    o_add_in1   = r_acc;
    o_add_in2   = (i_in_valid && w_in_ready) ? i_in_data : 8'd0;
    o_busy      = (r_state != S_IDLE);
    o_out_valid = 1'b0;
    o_out_data  = 16'd0;
    o_out_ovf   = 1'b0;
    if (r_state == S_DONE) begin
      o_out_valid = 1'b1;
      o_out_data  = r_acc;
      o_out_ovf   = r_ovf;
    end
  end

endmodule

// File: tb/tb_neuron_accum_ctrl.sv
// Directed bench for neuron_accum_ctrl with N_INPUTS=4 and a behavioural
// 1-cycle registered adder standing in for the shared one.
module tb_neuron_accum_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bias = 16'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic [15:0] add_in1;
  logic [7:0]  add_in2;
  logic [16:0] add_total;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] samp [N];

  always #5 clk = ~clk;

  neuron_accum_ctrl #(.N_INPUTS(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_bias      (bias),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_add_in1   (add_in1),
    .o_add_in2   (add_in2),
    .i_add_total (add_total),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_ovf   (out_ovf),
    .o_busy      (busy)
  );

  // Shared adder model: 16b signed + sign-extended 8b signed, registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) add_total <= 17'd0;
    else     add_total <= {add_in1[15], add_in1} + {{9{add_in2[7]}}, add_in2};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full run. gap: idle cycles after each accepted sample; hold: cycles
  // out_ready stays low once out_valid rises; poke: pulse start (bias 999)
  // while in ISSUE and while in DONE.
  task automatic run_neuron(input string tag, input logic [15:0] b,
                            input int gap, input int hold, input bit poke,
                            input logic [15:0] exp_data, input logic exp_ovf);
    int cyc, k, gapcnt, hs, stall, first_cyc;
    bit done, poked_issue, poked_done;
    logic [15:0] held;
    cyc = 0; k = 0; gapcnt = 0; hs = 0; stall = 0; first_cyc = -1;
    done = 0; poked_issue = 0; poked_done = 0; held = 16'd0;
    @(negedge clk);
    start = 1'b1; bias = b; out_ready = 1'b0;
    #1;
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      bias = 16'd999;
      in_valid = (k < N) && (gapcnt == 0);
      in_data  = (k < N) ? samp[k] : 8'd0;
      #1;
      if (in_valid && in_ready) begin
        chk({tag, " add_in2"}, 32'(add_in2), 32'(samp[k]));
        hs++; k++; gapcnt = gap;
        if (poke && !poked_issue) begin
          start = 1'b1; poked_issue = 1;
        end
      end else if (!in_valid && gapcnt > 0) begin
        gapcnt--;
      end
      if (out_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          held = out_data;
        end else begin
          chk({tag, " stall_data"}, 32'(out_data), 32'(held));
        end
        if (stall < hold) begin
          out_ready = 1'b0;
          stall++;
          if (poke && !poked_done) begin
            start = 1'b1; poked_done = 1;
          end
        end else begin
          out_ready = 1'b1;
          done = 1;
        end
      end
    end
    chk({tag, " finished"}, 32'(done), 32'd1);
    chk({tag, " out_data"}, 32'(held), 32'(exp_data));
    chk({tag, " out_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    chk({tag, " handshakes"}, 32'(hs), 32'(N));
    if (gap == 0) chk({tag, " latency"}, 32'(first_cyc), 32'(2 * N + 1));
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    #1;
    chk({tag, " valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, " busy_drop"}, 32'(busy), 32'd0);
  endtask

  task automatic load_basic();
    samp[0] = 8'd10; samp[1] = 8'hEC; samp[2] = 8'd30; samp[3] = 8'd5;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    in_valid = 1'b1; in_data = 8'd55;
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst add_in1", 32'(add_in1), 32'd0);
    chk("rst add_in2", 32'(add_in2), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle in_ready", 32'(in_ready), 32'd0);
    chk("idle add_in2", 32'(add_in2), 32'd0);
    in_valid = 1'b0;

    load_basic();
    run_neuron("basic", 16'd100, 0, 0, 1'b0, 16'd125, 1'b0);

    samp[0] = 8'd100; samp[1] = 8'd50; samp[2] = 8'hF6; samp[3] = 8'd1;
    run_neuron("pos_sat", 16'h7FBC, 0, 0, 1'b0, 16'h7FF6, 1'b1);

    samp[0] = 8'h9C; samp[1] = 8'h80; samp[2] = 8'd0; samp[3] = 8'd0;
    run_neuron("neg_sat", 16'h8008, 0, 0, 1'b0, 16'h8000, 1'b1);

    load_basic();
    run_neuron("backpressure", 16'd100, 3, 5, 1'b0, 16'd125, 1'b0);
    run_neuron("start_busy", 16'd100, 0, 2, 1'b1, 16'd125, 1'b0);

    samp[0] = 8'd100; samp[1] = 8'd50; samp[2] = 8'hF6; samp[3] = 8'd1;
    run_neuron("pos_sat2", 16'h7FBC, 0, 0, 1'b0, 16'h7FF6, 1'b1);
    load_basic();
    run_neuron("fresh_ovf", 16'd100, 0, 0, 1'b0, 16'd125, 1'b0);

    // Abort in ISSUE after two samples.
    @(negedge clk);
    start = 1'b1; bias = 16'd100;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = samp[0];
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = samp[1];
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst busy", 32'(busy), 32'd1);
    chk("pre_rst in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst busy", 32'(busy), 32'd0);
    chk("mid_rst in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst add_in1", 32'(add_in1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_neuron("post_rst", 16'd100, 0, 0, 1'b0, 16'd125, 1'b0);

    // Abort while a result is being offered.
    @(negedge clk);
    start = 1'b1; bias = 16'd100;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'd0;
    repeat (2 * N) @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("done out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("done_rst out_valid", 32'(out_valid), 32'd0);
    chk("done_rst out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/neuron_accum_ctrl.md
Name: neuron_accum_ctrl

Overview:
Sequencer that runs one neuron dot-product accumulation on the shared registered adder. The adder has a 1-cycle latency and adds 16b signed plus sign-extended 8b signed, giving a 17b exact total. This block loads a bias, streams N_INPUTS signed 8b weighted samples through the adder, saturates the running sum to 16b, and hands the result downstream through a valid/ready output. It sits between the weight×input product stream and the activation stage.

Parameters:
N_INPUTS, 8, samples accumulated per neuron evaluation (legal range 1..255)
CNT_W, $clog2(N_INPUTS+1), sample counter width (derived; not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to begin an accumulation; honoured only in IDLE
bias  input  16  signed initial accumulator value, sampled when start is accepted
in_valid  input  1  sample available
in_data  input  8  signed sample
in_ready  output  1  block accepts sample this cycle
add_in1  output  16  signed operand to adder in1
add_in2  output  8  signed operand to adder in2
add_total  input  17  adder registered 17b total (temp)
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_data  output  16  signed saturated accumulation result
out_ovf  output  1  sticky: at least one saturation occurred during this run
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, any state): state=IDLE, acc=0, cnt=0, ovf=0. All outputs 0: in_ready, out_valid, out_data, out_ovf, busy, add_in1, add_in2. The adder's active-low reset is driven from ~rst at integration.
- States: IDLE, ISSUE, CAPTURE, DONE.
- IDLE: on start=1, set acc<=bias, cnt<=0, ovf<=0, then go to ISSUE. Otherwise stay.
- ISSUE: in_ready=1.
  - On in_valid: drive add_in1=acc and add_in2=in_data in the same cycle, so the adder registers the sum at this edge. Go to CAPTURE.
  - Without in_valid: stay in ISSUE indefinitely.
- CAPTURE: add_total holds acc+sample.
  - Overflow condition: add_total[16] != add_total[15].
  - Saturated value: +overflow (total[16]=0) gives 16'h7FFF. −overflow (total[16]=1) gives 16'h8000. Otherwise total[15:0].
  - Update: acc<=saturated value, ovf<=ovf|overflow, cnt<=cnt+1.
  - Next state: if cnt==N_INPUTS-1 go to DONE, else ISSUE.
- Operand defaults: add_in1=acc in all states. add_in2=in_data only when in_valid&&in_ready, else 0.
- DONE: out_valid=1, out_data=acc, out_ovf=ovf. Hold these stable until out_ready=1, then go to IDLE. out_valid deasserts the next cycle.
- Timing:
  - Throughput: one sample per 2 cycles.
  - With in_valid held high, start-accepted edge to out_valid is 2·N_INPUTS+1 cycles.
  - Minimum start-to-start spacing is 2·N_INPUTS+2 cycles.
- Saturated acc feeds the next addition. No wrap-around ever reaches out_data.
- start outside IDLE is ignored, including in DONE while out_valid is high. bias is not resampled.
- in_valid in IDLE, CAPTURE or DONE is not consumed (in_ready=0). The sample must be held by the source.
- Reset during any state aborts the run. No partial result is emitted and out_valid drops immediately.

Test Plan:
- Basic sum: N_INPUTS=4, bias=100, samples 10,−20,30,5 with in_valid held high -> out_data=125, out_ovf=0, out_valid exactly 9 cycles after start accepted.
- Positive saturation: bias=32700, samples 100,50,−10,1 -> after first add acc=32767 and ovf set. Next adds give 32767 then 32757, then 32758. Result out_data=32758, out_ovf=1.
- Negative saturation: bias=−32760, samples −100,−128,0,0 -> out_data=−32768 (16'h8000), out_ovf=1.
- Backpressure: in_valid toggles with 3-cycle gaps and out_ready held low 5 cycles after out_valid -> same result as basic sum. out_data/out_valid are stable while stalled; exactly 4 handshakes occur on in_valid&&in_ready.
- start while busy: pulse start (bias=999) in ISSUE and again in DONE -> ignored, first result 125 unchanged. A start after return to IDLE begins a fresh run with ovf cleared.
- Reset mid-run: assert rst after 2 samples -> busy, in_ready and out_valid are 0 asynchronously. After release, a fresh basic run gives 125.
